psram_rx_capture: RTL
=====================

# psram_rx_capture

Receive-side stage for the serial PSRAM controller. It samples the PSRAM SO line (SIO[1]) during the read-data phase of a transaction, such as Read ID (0x9F) or a Fast Read. It assembles MSB-first bytes and buffers them in a small FIFO with a valid/ready interface to the consumer. The block sits directly downstream of the PSRAM command sequencer, which drives `cap_start` and `cap_en` in step with the PSRAM clock it generates.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.
- `LVL_W`, default 3: width of `level`; must equal log2(FIFO_DEPTH)+1.
- `sys_clk`  in  1  system clock; all sampling and state updates occur on its rising edge.
- `sys_reset_n`  in  1  asynchronous, active-low reset.
- `so`  in  1  serial data from PSRAM SIO[1].
- `cap_start`  in  1  one-cycle pulse marking the start of a read-data phase.
- `cap_en`  in  1  when high, `so` holds a valid data bit this cycle.
- `flush`  in  1  synchronous FIFO clear.
- `out_data`  out  8  byte at the FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head byte.
- `level`  out  LVL_W  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a completed byte was dropped because the FIFO was full.
- `byte_cnt`  out  8  bytes completed since the last `cap_start`; saturates at 255.
- `id_ok`, `id_fail`  out  1 each  ID check result; present only with `PSRAM_RX_IDCHK_EN`.

## Operation
- Reset values: shift register = 0x00, bit counter = 0, FIFO empty, `out_valid` = 0, `out_data` = 0x00, `level` = 0, `overflow` = 0, `byte_cnt` = 0, `id_ok` = 0, `id_fail` = 0.
- Bit capture: on each edge where `cap_en` = 1, `shreg <= {shreg[6:0], so}` and the bit counter (3 bits) increments.
- Byte completion: on the edge that takes the 8th bit (counter = 7), the completed byte `{shreg[6:0], so}` is pushed, the counter wraps to 0 and `byte_cnt` increments (saturating).
- `cap_start`: clears the bit counter, `shreg`, `byte_cnt`, `overflow` and the ID state. It does not flush the FIFO.
- `cap_start` and `cap_en` in the same cycle: the start takes effect first, and that cycle's `so` becomes bit 7 of the new byte (counter = 1 afterwards).
- A partial byte left when `cap_en` stops is retained until the next `cap_start`. It is never pushed.
- FIFO pointers are LVL_W bits wide. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
- Pop occurs when `out_valid & out_ready`.
- Push when not full: the byte is written.
- Push when full with a simultaneous pop: the byte is written and `level` is unchanged.
- Push when full with no pop: the byte is dropped and `overflow` is set to 1.
- Pop when empty: ignored.
- `flush`: empties the FIFO and takes priority over push and pop in the same cycle. It does not touch the shift register or `overflow`.
- `out_data` is combinational from the head entry. When the FIFO is empty it is don't-care, and the bench must not check it.

## Timing
- Latency: 8th bit sampled at edge N, so `out_valid` = 1 and `out_data` is valid after edge N; the byte is poppable at edge N+1.
- `cap_en` gaps of any length are allowed between bits; bit order is preserved.
- Sustained throughput is 1 byte per 8 `cap_en` cycles with `out_ready` tied high. The FIFO never fills in this case.
- Reset assertion mid-byte or mid-FIFO discards everything immediately (asynchronous).

## Configuration
- `PSRAM_RX_IDCHK_EN` defined: the first two bytes completed after `cap_start` are compared to MFID 0x0D and KGD 0x5D.
  - If both match, `id_ok` is set to 1 on the 2nd byte's completion edge.
  - If either mismatches, `id_fail` is set to 1 on that byte's completion edge.
  - Both flags are sticky until `cap_start` or reset.
  - The bytes are still pushed to the FIFO normally.
- `PSRAM_RX_IDCHK_EN` undefined: the ports `id_ok` and `id_fail` are absent and no comparison logic is built.

## Test plan
- Reset, then `cap_start`, then 16 `cap_en` cycles carrying 0x0D, 0x5D with `out_ready` = 1 → `out_data` 0x0D then 0x5D, each valid 1 cycle after its 8th bit; `byte_cnt` = 2; with the macro, `id_ok` = 1 and `id_fail` = 0.
- ID mismatch: 0x0D, 0x5C → `id_fail` = 1 at the 16th bit, `id_ok` = 0.
- Backpressure: `out_ready` = 0, push 5 bytes 0x01–0x05 with FIFO_DEPTH = 4 → `level` = 4, `overflow` = 1, FIFO drains 0x01–0x04, 0x05 is lost.
- Full with simultaneous pop and push → `level` stays 4, no overflow; bytes come out in order.
- Pulse `cap_start` after 3 bits of 0xA5 (bits 1,0,1), then send 0x3C → only 0x3C is delivered; `byte_cnt` = 1.
- Assert `sys_reset_n` low with 2 bytes queued and a partial byte → `out_valid` = 0, `level` = 0, `byte_cnt` = 0 immediately, before the next edge.

Source files
------------

// File: rtl/psram_rx_capture.sv
// -----------------------------------------------------------------------------
// psram_rx_capture
//
// Receive-side capture stage for the serial PSRAM controller. It samples the
// PSRAM SO line during the read-data phase of a transaction, assembles bytes
// MSB-first and queues them in a small FIFO with a valid/ready interface to
// the consumer.
//
// Optional feature macro: PSRAM_RX_IDCHK_EN
//   When defined, the first two bytes after cap_start are checked against the
//   expected manufacturer ID (0x0D) and known-good-die code (0x5D). The result
//   is reported on id_ok / id_fail. When undefined, those ports and the
//   comparison logic are absent.
//
// Parameters
//   FIFO_DEPTH : FIFO entries (power of 2, >= 2)
//   LVL_W      : width of level, log2(FIFO_DEPTH)+1
//
// Ports
//   sys_clk     : system clock, all state updates on its rising edge
//   sys_reset_n : asynchronous active-low reset
//   so          : serial data from PSRAM SIO[1]
//   cap_start   : one-cycle pulse marking the start of a read-data phase
//   cap_en      : so holds a valid data bit this cycle
//   flush       : synchronous FIFO clear (beats push and pop)
//   out_data    : byte at the FIFO head (0x00 while empty)
//   out_valid   : FIFO not empty
//   out_ready   : consumer accepts the head byte
//   level       : current FIFO occupancy
//   overflow    : sticky, a completed byte was dropped because FIFO was full
//   byte_cnt    : bytes completed since the last cap_start, saturates at 255
//   id_ok       : both ID bytes matched (PSRAM_RX_IDCHK_EN only)
//   id_fail     : an ID byte mismatched (PSRAM_RX_IDCHK_EN only)
// -----------------------------------------------------------------------------
module psram_rx_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             so,
  input  logic             cap_start,
  input  logic             cap_en,
  input  logic             flush,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [7:0]       byte_cnt
`ifdef PSRAM_RX_IDCHK_EN
  ,
  output logic             id_ok,
  output logic             id_fail
`endif
);

  localparam int AW = LVL_W - 1;

  // ---------------------------------------------------------------------------
  // Bit capture
  // ---------------------------------------------------------------------------
  // Only the seven most recent bits are kept: the eighth bit completes a byte
  // and goes straight to the FIFO together with them.
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  logic [6:0] sh_eff;
  logic [2:0] cnt_eff;
  logic       byte_done;
  logic [7:0] push_byte;

  // cap_start acts before the bit sampled in the same cycle, so the capture
  // path works from the "already cleared" view of the shift state.
  always_comb begin
    sh_eff    = cap_start ? 7'd0 : shreg;
    cnt_eff   = cap_start ? 3'd0 : bit_cnt;
    byte_done = cap_en && (cnt_eff == 3'd7);
    push_byte = {sh_eff, so};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      shreg   <= 7'd0;
      bit_cnt <= 3'd0;
    end else if (cap_en) begin
      shreg   <= {sh_eff[5:0], so};
      bit_cnt <= cnt_eff + 3'd1;
    end else if (cap_start) begin
      shreg   <= 7'd0;
      bit_cnt <= 3'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      byte_cnt <= 8'd0;
    end else if (cap_start) begin
      // A byte cannot complete in a cap_start cycle, so clearing wins outright.
      byte_cnt <= 8'd0;
    end else if (byte_done && (byte_cnt != 8'hFF)) begin
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop       = !empty && out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle;
    // the freed slot is exactly the one being written.
    push_ok   = byte_done && (!full || pop) && !flush;
    push_drop = byte_done && full && !pop && !flush;
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and out_data is masked while the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_byte;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      overflow <= 1'b0;
    end else if (cap_start) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign level     = wr_ptr - rd_ptr;

`ifdef PSRAM_RX_IDCHK_EN
  // ---------------------------------------------------------------------------
  // ID check on the first two bytes after cap_start
  // ---------------------------------------------------------------------------
  localparam logic [7:0] MFID = 8'h0D;
  localparam logic [7:0] KGD  = 8'h5D;

  typedef enum logic [1:0] {
    ID_MFID,
    ID_KGD,
    ID_DONE
  } id_state_t;

  id_state_t id_state;
  logic      mfid_match;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      id_state   <= ID_MFID;
      mfid_match <= 1'b0;
      id_ok      <= 1'b0;
      id_fail    <= 1'b0;
    end else if (cap_start) begin
      id_state   <= ID_MFID;
      mfid_match <= 1'b0;
      id_ok      <= 1'b0;
      id_fail    <= 1'b0;
    end else if (byte_done) begin
      case (id_state)
        ID_MFID: begin
          id_state <= ID_KGD;
          if (push_byte == MFID) mfid_match <= 1'b1;
          else                   id_fail    <= 1'b1;
        end
        ID_KGD: begin
          id_state <= ID_DONE;
          if (push_byte != KGD) id_fail <= 1'b1;
          else if (mfid_match)  id_ok   <= 1'b1;
        end
        default: id_state <= ID_DONE;
      endcase
    end
  end
`endif

endmodule
